// File: rtl/serial_word_rx.sv
// ============================================================================
// Module   : serial_word_rx
// Purpose  : Serial-to-parallel frame receiver. Samples a framed stream
//            (start, WIDTH data bits LSB first, optional even parity, stop)
//            on sample-enabled edges and presents the last good word on Q,
//            with 1-cycle valid / frame_err (/ par_err) strobes.
// Config   : define PARITY_EN to add an even-parity bit to the frame and the
//            par_err output port.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module serial_word_rx #(
  parameter int WIDTH = 4
) (
  input  logic             clk,
  input  logic             r,
  input  logic             sen,
  input  logic             sin,
  output logic [WIDTH-1:0] Q,
  output logic             valid,
  output logic             frame_err,
  output logic             busy
`ifdef PARITY_EN
  ,
  output logic             par_err
`endif
);

  localparam int             CW       = (WIDTH > 1) ? $clog2(WIDTH) : 1;
  localparam logic [CW-1:0]  LAST_BIT = CW'(WIDTH - 1);

  typedef enum logic [2:0] {
    S_IDLE  = 3'd0,
    S_DATA  = 3'd1,
    S_PAR   = 3'd2,
    S_STOP  = 3'd3,
    S_BREAK = 3'd4
  } state_t;

  state_t           state_q, state_d;
  logic [CW-1:0]    cnt_q, cnt_d;
  logic [WIDTH-1:0] shift_q, shift_d;
  logic [WIDTH-1:0] q_q, q_d;
  logic             valid_q, valid_d;
  logic             frame_err_q, frame_err_d;
  logic             busy_q, busy_d;
  logic             w_par_bad;

`ifdef PARITY_EN
  logic             par_q, par_d;
  logic             par_err_q, par_err_d;

  // Even parity: data bits plus parity bit must XOR to zero.
  assign w_par_bad = ^{shift_q, par_q};
`else
  assign w_par_bad = 1'b0;
`endif

  // Next-state, datapath and strobe computation; everything holds when sen=0.
  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    shift_d     = shift_q;
    q_d         = q_q;
    valid_d     = 1'b0;
    frame_err_d = 1'b0;
`ifdef PARITY_EN
    par_d       = par_q;
    par_err_d   = 1'b0;
`endif
    if (sen) begin
      case (state_q)
        S_IDLE: begin
          if (!sin) begin
            state_d = S_DATA;
            cnt_d   = '0;
          end
        end
        S_DATA: begin
          // LSB arrives first, so shifting in at the MSB leaves it at bit 0.
          shift_d = {sin, shift_q[WIDTH-1:1]};
          cnt_d   = cnt_q + CW'(1);
          if (cnt_q == LAST_BIT) begin
            cnt_d = '0;
`ifdef PARITY_EN
            state_d = S_PAR;
`else
            state_d = S_STOP;
`endif
          end
        end
`ifdef PARITY_EN
        S_PAR: begin
          par_d   = sin;
          state_d = S_STOP;
        end
`endif
        S_STOP: begin
          if (sin) begin
            state_d = S_IDLE;
            if (w_par_bad) begin
`ifdef PARITY_EN
              par_err_d = 1'b1;
`endif
            end else begin
              q_d     = shift_q;
              valid_d = 1'b1;
            end
          end else begin
            frame_err_d = 1'b1;
            state_d     = S_BREAK;
          end
        end
        S_BREAK: begin
          // A low line here is the tail of the break, never a start bit.
          if (sin) state_d = S_IDLE;
        end
        default: state_d = S_IDLE;
      endcase
    end
    busy_d = (state_d != S_IDLE);
  end

  // State and output registers; reset discards any partial frame.
  always_ff @(posedge clk or posedge r) begin
    if (r) begin
      state_q     <= S_IDLE;
      cnt_q       <= '0;
      shift_q     <= '0;
      q_q         <= '0;
      valid_q     <= 1'b0;
      frame_err_q <= 1'b0;
      busy_q      <= 1'b0;
`ifdef PARITY_EN
      par_q       <= 1'b0;
      par_err_q   <= 1'b0;
`endif
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      shift_q     <= shift_d;
      q_q         <= q_d;
      valid_q     <= valid_d;
      frame_err_q <= frame_err_d;
      busy_q      <= busy_d;
`ifdef PARITY_EN
      par_q       <= par_d;
      par_err_q   <= par_err_d;
`endif
    end
  end

  assign Q         = q_q;
  assign valid     = valid_q;
  assign frame_err = frame_err_q;
  assign busy      = busy_q;
`ifdef PARITY_EN
  assign par_err   = par_err_q;
`endif

endmodule

`default_nettype wire

// File: tb/tb_serial_word_rx.sv
// ============================================================================
// Module   : tb_serial_word_rx
// Purpose  : Directed self-checking bench for serial_word_rx (WIDTH=4).
//            Parity frames are exercised when PARITY_EN is defined.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_serial_word_rx;

  localparam int WIDTH = 4;

  logic             clk = 1'b0;
  logic             r;
  logic             sen;
  logic             sin;
  logic [WIDTH-1:0] Q;
  logic             valid;
  logic             frame_err;
  logic             busy;
`ifdef PARITY_EN
  logic             par_err;
`endif

  int n_assert = 0;
  int n_fail   = 0;
  int nv, nfe, npe;

  serial_word_rx #(.WIDTH(WIDTH)) dut (
    .clk       (clk),
    .r         (r),
    .sen       (sen),
    .sin       (sin),
    .Q         (Q),
    .valid     (valid),
    .frame_err (frame_err),
    .busy      (busy)
`ifdef PARITY_EN
    ,
    .par_err   (par_err)
`endif
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Sends start, data LSB first, [parity], stop; optionally a sen=0 gap after
  // every bit with sin held. Returns the strobe counts seen during the frame.
  task automatic send_frame(input logic [3:0] data, input logic stop_bit,
                            input bit gap, input bit bad_par,
                            output int o_nv, output int o_nfe, output int o_npe);
    logic [7:0] bits;
    int n;
    bits    = '1;
    bits[0] = 1'b0;
    bits[4:1] = data;
`ifdef PARITY_EN
    bits[5] = (^data) ^ bad_par;
    bits[6] = stop_bit;
    n = 7;
`else
    bits[5] = stop_bit;
    bits[7] = bad_par;
    n = 6;
`endif
    o_nv = 0; o_nfe = 0; o_npe = 0;
    for (int i = 0; i < n; i++) begin
      sen = 1'b1;
      sin = bits[i];
      tick();
      o_nv  += int'(valid);
      o_nfe += int'(frame_err);
`ifdef PARITY_EN
      o_npe += int'(par_err);
`endif
      if (gap) begin
        sen = 1'b0;
        tick();
        check("gap_strobes", {30'd0, valid, frame_err}, 32'd0);
        sen = 1'b1;
      end
    end
  endtask

  initial begin
    // 1. reset, then idle line
    r = 1'b1; sen = 1'b1; sin = 1'b1;
    tick();
    check("rst_Q", Q, 0);
    check("rst_busy", busy, 0);
    r = 1'b0;
    for (int i = 0; i < 5; i++) begin
      tick();
      check("idle_strobes", {valid, frame_err, busy}, 0);
      check("idle_Q", Q, 0);
    end

    // 2. frame 0,1,0,1,1,1 -> 4'hD
    send_frame(4'hD, 1'b1, 1'b0, 1'b0, nv, nfe, npe);
    check("f2_valid_cnt", nv, 1);
    check("f2_fe_cnt", nfe, 0);
    check("f2_Q", Q, 4'hD);
    check("f2_busy_after", busy, 0);
    sin = 1'b1; tick();
    check("f2_valid_1clk", valid, 0);

    // 3. same frame with sen gaps
    send_frame(4'hD, 1'b1, 1'b1, 1'b0, nv, nfe, npe);
    check("f3_valid_cnt", nv, 1);
    check("f3_Q", Q, 4'hD);
    check("f3_busy_after", busy, 0);

    // 4. bad stop -> frame_err, break until sin=1
    send_frame(4'h6, 1'b0, 1'b0, 1'b0, nv, nfe, npe);
    check("f4_fe_cnt", nfe, 1);
    check("f4_valid_cnt", nv, 0);
    check("f4_Q_hold", Q, 4'hD);
    check("f4_busy_break", busy, 1);
    sin = 1'b0; tick();
    check("f4_break_hold", busy, 1);
    check("f4_fe_1clk", frame_err, 0);
    sin = 1'b1; tick();
    check("f4_break_exit", busy, 0);
    send_frame(4'h8, 1'b1, 1'b0, 1'b0, nv, nfe, npe);
    check("f4b_valid_cnt", nv, 1);
    check("f4b_Q", Q, 4'h8);

    // 5. async reset after the 2nd data bit
    sin = 1'b0; tick();
    sin = 1'b1; tick();
    sin = 1'b1; tick();
    check("f5_busy_mid", busy, 1);
    r = 1'b1;
    #1;
    check("f5_async_Q", Q, 0);
    check("f5_async_out", {valid, frame_err, busy}, 0);
    sin = 1'b0; tick();
    check("f5_rst_hold", {valid, frame_err, busy}, 0);
    r = 1'b0; sin = 1'b1; tick();
    check("f5_after_rst", {valid, frame_err, busy}, 0);
    send_frame(4'h3, 1'b1, 1'b0, 1'b0, nv, nfe, npe);
    check("f5_valid_cnt", nv, 1);
    check("f5_Q", Q, 4'h3);
    // back-to-back frame, start bit right after stop
    send_frame(4'h5, 1'b1, 1'b0, 1'b0, nv, nfe, npe);
    check("b2b_valid_cnt", nv, 1);
    check("b2b_Q", Q, 4'h5);

`ifdef PARITY_EN
    // 6. parity good, then parity bad
    send_frame(4'hD, 1'b1, 1'b0, 1'b0, nv, nfe, npe);
    check("p_ok_valid", nv, 1);
    check("p_ok_perr", npe, 0);
    check("p_ok_Q", Q, 4'hD);
    send_frame(4'h2, 1'b1, 1'b0, 1'b1, nv, nfe, npe);
    check("p_bad_perr", npe, 1);
    check("p_bad_valid", nv, 0);
    check("p_bad_fe", nfe, 0);
    check("p_bad_Q", Q, 4'hD);
    sin = 1'b1; tick();
    check("p_perr_1clk", par_err, 0);
`endif

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule

`default_nettype wire
